// File: rtl/ghost_mode_ctrl.sv
// Per-ghost mode sequencer: jail release, scatter/chase schedule, frightened and eaten cycles.
// Optional Elroy behaviour (chase code while scattering when few dots remain) under GHOST_ELROY_EN.
module ghost_mode_ctrl #(
    parameter int RELEASE_TICKS = 32,
    parameter int SCATTER_LONG  = 112,
    parameter int SCATTER_SHORT = 80,
    parameter int CHASE_TICKS   = 320,
    parameter int FRIGHT_L0     = 96,
    parameter int FRIGHT_L1     = 48
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       game_reset,
    input  logic       level,
    input  logic       fright,
    input  logic       eaten,
    input  logic       dots_low,
    input  logic [4:0] GhostPos_x,
    input  logic [4:0] GhostPos_y,
    output logic [1:0] GhostMode,
    output logic       frightened,
    output logic       mode_change
);

    typedef enum logic [2:0] {
        JAIL_WAIT,
        EXIT,
        SCATTER,
        CHASE,
        EATEN
    } state_t;

    localparam logic [9:0] REL_LIM    = 10'(RELEASE_TICKS);
    // Reload after being eaten so the release compare fires on the 8th tick.
    localparam logic [9:0] REL_RELOAD = (RELEASE_TICKS >= 8) ? 10'(RELEASE_TICKS - 8) : 10'd0;

    state_t     state;
    logic [9:0] sched_cnt;
    logic [9:0] fright_cnt;
    logic [2:0] phase;

    logic [9:0]  phase_limit;
    logic [10:0] sched_next;
    logic        rel_done;
    logic        phase_done;
    logic        at_exit_tile;
    logic        at_home_tile;
    logic [9:0]  fright_load;
    logic [1:0]  mode_code;

    always_comb begin
        phase_limit = 10'(CHASE_TICKS);
        case (phase)
            3'd0, 3'd2: phase_limit = level ? 10'(SCATTER_SHORT) : 10'(SCATTER_LONG);
            3'd4, 3'd6: phase_limit = 10'(SCATTER_SHORT);
            default:    phase_limit = 10'(CHASE_TICKS);
        endcase
    end

    assign sched_next   = {1'b0, sched_cnt} + 11'd1;
    assign rel_done     = sched_next >= {1'b0, REL_LIM};
    assign phase_done   = (phase != 3'd7) && (sched_next >= {1'b0, phase_limit});
    assign at_exit_tile = (GhostPos_x == 5'd10) && (GhostPos_y == 5'd9);
    assign at_home_tile = (GhostPos_x == 5'd10) && (GhostPos_y == 5'd12);
    assign fright_load  = level ? 10'(FRIGHT_L1) : 10'(FRIGHT_L0);

    always_comb begin
        mode_code = 2'b00;
        case (state)
            SCATTER: mode_code = 2'b01;
            CHASE:   mode_code = 2'b10;
            EATEN:   mode_code = 2'b11;
            default: mode_code = 2'b00;
        endcase
`ifdef GHOST_ELROY_EN
        if (state == SCATTER && dots_low)
            mode_code = 2'b10;
`endif
    end

`ifndef GHOST_ELROY_EN
    logic unused_dots_low;
    assign unused_dots_low = dots_low;
`endif

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= JAIL_WAIT;
            sched_cnt   <= 10'd0;
            fright_cnt  <= 10'd0;
            phase       <= 3'd0;
            frightened  <= 1'b0;
            mode_change <= 1'b0;
            GhostMode   <= 2'b00;
        end else begin
            mode_change <= 1'b0;
            GhostMode   <= mode_code;
            if (game_reset) begin
                state      <= JAIL_WAIT;
                sched_cnt  <= 10'd0;
                fright_cnt <= 10'd0;
                phase      <= 3'd0;
                frightened <= 1'b0;
                GhostMode  <= 2'b00;
            end else begin
                case (state)
                    JAIL_WAIT: begin
                        if (tick) begin
                            if (rel_done) begin
                                state     <= EXIT;
                                sched_cnt <= 10'd0;
                            end else begin
                                sched_cnt <= sched_next[9:0];
                            end
                        end
                    end
                    EXIT: begin
                        if (at_exit_tile) begin
                            state     <= phase[0] ? CHASE : SCATTER;
                            sched_cnt <= 10'd0;
                        end
                    end
                    SCATTER, CHASE: begin
                        if (eaten && frightened) begin
                            state      <= EATEN;
                            frightened <= 1'b0;
                            fright_cnt <= 10'd0;
                        end else if (fright) begin
                            frightened <= 1'b1;
                            fright_cnt <= fright_load;
                            if (!frightened)
                                mode_change <= 1'b1;
                        end else if (tick) begin
                            if (frightened) begin
                                if (fright_cnt <= 10'd1) begin
                                    frightened <= 1'b0;
                                    fright_cnt <= 10'd0;
                                end else begin
                                    fright_cnt <= fright_cnt - 10'd1;
                                end
                            end else if (phase_done) begin
                                phase       <= phase + 3'd1;
                                sched_cnt   <= 10'd0;
                                state       <= (state == SCATTER) ? CHASE : SCATTER;
                                mode_change <= 1'b1;
                            end else if (sched_cnt != 10'h3FF) begin
                                sched_cnt <= sched_next[9:0];
                            end
                        end
                    end
                    EATEN: begin
                        if (at_home_tile) begin
                            state     <= JAIL_WAIT;
                            sched_cnt <= REL_RELOAD;
                        end
                    end
                    default: state <= JAIL_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Directed bench for ghost_mode_ctrl: a table of operations with expected outputs,
// followed by a hand-written asynchronous-reset sequence.
module tb_ghost_mode_ctrl;

    logic       clk_50mhz = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       game_reset;
    logic       level;
    logic       fright;
    logic       eaten;
    logic       dots_low;
    logic [4:0] GhostPos_x;
    logic [4:0] GhostPos_y;
    logic [1:0] GhostMode;
    logic       frightened;
    logic       mode_change;

    ghost_mode_ctrl dut (
        .clk_50mhz  (clk_50mhz),
        .rst_n      (rst_n),
        .tick       (tick),
        .game_reset (game_reset),
        .level      (level),
        .fright     (fright),
        .eaten      (eaten),
        .dots_low   (dots_low),
        .GhostPos_x (GhostPos_x),
        .GhostPos_y (GhostPos_y),
        .GhostMode  (GhostMode),
        .frightened (frightened),
        .mode_change(mode_change)
    );

    always #5 clk_50mhz = ~clk_50mhz;

`ifdef GHOST_ELROY_EN
    localparam logic [1:0] ELROY_MODE = 2'b10;
`else
    localparam logic [1:0] ELROY_MODE = 2'b01;
`endif

    typedef enum int {OP_NOP, OP_TICKS, OP_POS, OP_FRIGHT, OP_EATEN, OP_EATFR, OP_GRESET} op_t;

    typedef struct {
        op_t        op;
        int         n;
        logic [4:0] x;
        logic [4:0] y;
        logic       lvl;
        logic       dots;
        logic [1:0] exp_mode;
        logic       exp_fr;
        int         exp_mc;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;
    int   mc_total = 0;

    always @(negedge clk_50mhz)
        if (mode_change) mc_total++;

    function automatic vec_t v(op_t op, int n, int x, int y, bit lvl, bit dots,
                               int mode, bit fr, int mc, string name);
        vec_t r;
        r.op = op; r.n = n; r.x = 5'(x); r.y = 5'(y); r.lvl = lvl; r.dots = dots;
        r.exp_mode = 2'(mode); r.exp_fr = fr; r.exp_mc = mc; r.name = name;
        return r;
    endfunction

    task automatic check(string name, int got, int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick_n(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_50mhz) tick = 1'b1;
            @(negedge clk_50mhz) tick = 1'b0;
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk_50mhz);
        case (which)
            0: fright = 1'b1;
            1: eaten = 1'b1;
            2: begin eaten = 1'b1; fright = 1'b1; end
            default: game_reset = 1'b1;
        endcase
        @(negedge clk_50mhz);
        fright = 1'b0; eaten = 1'b0; game_reset = 1'b0;
    endtask

    task automatic set_pos(input logic [4:0] x, input logic [4:0] y);
        @(negedge clk_50mhz);
        GhostPos_x = x; GhostPos_y = y;
        @(negedge clk_50mhz);
        GhostPos_x = 5'd0; GhostPos_y = 5'd0;
    endtask

    initial begin
        int mc_before;
        rst_n = 1'b0; tick = 1'b0; game_reset = 1'b0; level = 1'b0;
        fright = 1'b0; eaten = 1'b0; dots_low = 1'b0;
        GhostPos_x = 5'd0; GhostPos_y = 5'd0;

        vecs.push_back(v(OP_NOP,    0,   0,  0, 0, 0, 0, 0, 0, "reset"));
        vecs.push_back(v(OP_TICKS,  31,  0,  0, 0, 0, 0, 0, 0, "jail_31_ticks"));
        vecs.push_back(v(OP_POS,    0,  10,  9, 0, 0, 0, 0, 0, "jail_ignores_exit_tile"));
        vecs.push_back(v(OP_TICKS,  1,   0,  0, 0, 0, 0, 0, 0, "tick_32_exit"));
        vecs.push_back(v(OP_POS,    0,  10,  9, 0, 0, 1, 0, 0, "exit_to_scatter"));
        vecs.push_back(v(OP_TICKS,  111, 0,  0, 0, 0, 1, 0, 0, "scatter0_111"));
        vecs.push_back(v(OP_TICKS,  1,   0,  0, 0, 0, 2, 0, 1, "scatter0_limit"));
        vecs.push_back(v(OP_TICKS,  319, 0,  0, 0, 0, 2, 0, 0, "chase1_319"));
        vecs.push_back(v(OP_TICKS,  1,   0,  0, 0, 0, 1, 0, 1, "chase1_limit"));
        vecs.push_back(v(OP_TICKS,  79,  0,  0, 1, 0, 1, 0, 0, "scatter2_l1_79"));
        vecs.push_back(v(OP_TICKS,  1,   0,  0, 1, 0, 2, 0, 1, "scatter2_l1_limit"));
        vecs.push_back(v(OP_TICKS,  100, 0,  0, 0, 0, 2, 0, 0, "chase3_100"));
        vecs.push_back(v(OP_FRIGHT, 0,   0,  0, 0, 0, 2, 1, 1, "fright_on"));
        vecs.push_back(v(OP_TICKS,  50,  0,  0, 0, 0, 2, 1, 0, "fright_50"));
        vecs.push_back(v(OP_FRIGHT, 0,   0,  0, 0, 0, 2, 1, 0, "fright_reload"));
        vecs.push_back(v(OP_TICKS,  95,  0,  0, 0, 0, 2, 1, 0, "fright_95_after_reload"));
        vecs.push_back(v(OP_TICKS,  1,   0,  0, 0, 0, 2, 0, 0, "fright_end_96"));
        vecs.push_back(v(OP_TICKS,  219, 0,  0, 0, 0, 2, 0, 0, "chase3_resume_219"));
        vecs.push_back(v(OP_TICKS,  1,   0,  0, 0, 0, 1, 0, 1, "chase3_limit"));
        vecs.push_back(v(OP_TICKS,  79,  0,  0, 0, 0, 1, 0, 0, "scatter4_79"));
        vecs.push_back(v(OP_TICKS,  1,   0,  0, 0, 0, 2, 0, 1, "scatter4_limit"));
        vecs.push_back(v(OP_TICKS,  320, 0,  0, 0, 0, 1, 0, 1, "chase5_full"));
        vecs.push_back(v(OP_TICKS,  80,  0,  0, 0, 0, 2, 0, 1, "scatter6_full"));
        vecs.push_back(v(OP_TICKS,  2000,0,  0, 0, 0, 2, 0, 0, "phase7_hold"));
        vecs.push_back(v(OP_EATEN,  0,   0,  0, 0, 0, 2, 0, 0, "eaten_not_frightened"));
        vecs.push_back(v(OP_FRIGHT, 0,   0,  0, 1, 0, 2, 1, 1, "fright_l1_on"));
        vecs.push_back(v(OP_TICKS,  47,  0,  0, 1, 0, 2, 1, 0, "fright_l1_47"));
        vecs.push_back(v(OP_TICKS,  1,   0,  0, 1, 0, 2, 0, 0, "fright_l1_end"));
        vecs.push_back(v(OP_FRIGHT, 0,   0,  0, 0, 0, 2, 1, 1, "fright_again"));
        vecs.push_back(v(OP_EATFR,  0,   0,  0, 0, 0, 3, 0, 0, "eaten_and_fright"));
        vecs.push_back(v(OP_POS,    0,  10,  9, 0, 0, 3, 0, 0, "eaten_wrong_tile"));
        vecs.push_back(v(OP_POS,    0,  10, 12, 0, 0, 0, 0, 0, "eaten_home"));
        vecs.push_back(v(OP_TICKS,  7,   0,  0, 0, 0, 0, 0, 0, "rejail_7"));
        vecs.push_back(v(OP_POS,    0,  10,  9, 0, 0, 0, 0, 0, "rejail_still_jailed"));
        vecs.push_back(v(OP_TICKS,  1,   0,  0, 0, 0, 0, 0, 0, "rejail_8th"));
        vecs.push_back(v(OP_POS,    0,  10,  9, 0, 0, 2, 0, 0, "reexit_phase7_chase"));
        vecs.push_back(v(OP_FRIGHT, 0,   0,  0, 0, 0, 2, 1, 1, "fright_before_eat"));
        vecs.push_back(v(OP_EATEN,  0,   0,  0, 0, 0, 3, 0, 0, "eaten"));
        vecs.push_back(v(OP_GRESET, 0,   0,  0, 0, 0, 0, 0, 0, "game_reset_in_eaten"));
        vecs.push_back(v(OP_FRIGHT, 0,   0,  0, 0, 0, 0, 0, 0, "fright_in_jail"));
        vecs.push_back(v(OP_TICKS,  32,  0,  0, 0, 0, 0, 0, 0, "release_after_greset"));
        vecs.push_back(v(OP_POS,    0,  10,  9, 0, 0, 1, 0, 0, "phase0_scatter"));
        vecs.push_back(v(OP_NOP,    0,   0,  0, 0, 1, ELROY_MODE, 0, 0, "elroy_dots_low"));

        repeat (3) @(negedge clk_50mhz);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk_50mhz);
            level = vecs[i].lvl;
            dots_low = vecs[i].dots;
            mc_before = mc_total;
            case (vecs[i].op)
                OP_TICKS:  tick_n(vecs[i].n);
                OP_POS:    set_pos(vecs[i].x, vecs[i].y);
                OP_FRIGHT: pulse(0);
                OP_EATEN:  pulse(1);
                OP_EATFR:  pulse(2);
                OP_GRESET: pulse(3);
                default:   ;
            endcase
            repeat (3) @(negedge clk_50mhz);
            check({vecs[i].name, ".mode"}, int'(GhostMode), int'(vecs[i].exp_mode));
            check({vecs[i].name, ".frightened"}, int'(frightened), int'(vecs[i].exp_fr));
            check({vecs[i].name, ".mode_change_pulses"}, mc_total - mc_before, vecs[i].exp_mc);
        end

        // Asynchronous reset while frightened in chase, right after the fright edge.
        dots_low = 1'b0;
        tick_n(112);
        repeat (3) @(negedge clk_50mhz);
        check("async.pre_chase", int'(GhostMode), 2);
        @(negedge clk_50mhz) fright = 1'b1;
        @(posedge clk_50mhz);
        #1;
        fright = 1'b0;
        check("async.pre_mode_change", int'(mode_change), 1);
        check("async.pre_frightened", int'(frightened), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async.mode", int'(GhostMode), 0);
        check("async.frightened", int'(frightened), 0);
        check("async.mode_change", int'(mode_change), 0);
        @(negedge clk_50mhz) rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ghost_mode_ctrl.md
Name: ghost_mode_ctrl

Overview:
Per-ghost mode sequencer that generates the 2-bit GhostMode code consumed by the ghost target-selection logic. It sequences jail release, the timed scatter/chase schedule, frightened periods triggered by power pellets, and the eaten/return-to-jail cycle. There is one instance per ghost. Each instance is clocked on clk_50mhz and advanced by a game-rate tick enable.

Parameters:
RELEASE_TICKS, 32, ticks spent in jail before exit starts (per-ghost stagger).
SCATTER_LONG, 112, ticks of scatter for schedule phases 0 and 2 (level 0).
SCATTER_SHORT, 80, ticks of scatter for phases 4 and 6, and for all scatter phases on level 1.
CHASE_TICKS, 320, ticks of chase for phases 1, 3 and 5.
FRIGHT_L0, 96, frightened duration in ticks on level 0.
FRIGHT_L1, 48, frightened duration in ticks on level 1.
All parameter values must be ≤ 1023, because the counters are 10 bits.

Ports:
clk_50mhz  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
tick  in  1  one-cycle game tick enable; timers advance only on tick.
game_reset  in  1  synchronous restart (level start or Pac-Man death).
level  in  1  0 = level 0, 1 = level 1.
fright  in  1  one-cycle pulse when a power pellet is eaten.
eaten  in  1  one-cycle pulse when Pac-Man collides with this ghost.
dots_low  in  1  high when few dots remain (used only by the optional feature).
GhostPos_x  in  5  current ghost tile x.
GhostPos_y  in  5  current ghost tile y.
GhostMode  out  2  00 jail/exit, 01 scatter, 10 attack, 11 return to jail.
frightened  out  1  ghost is vulnerable.
mode_change  out  1  one-cycle pulse requesting a direction reversal.

Behaviour:
- Reset (rst_n low, asynchronous) and game_reset (synchronous) both force:
  - state JAIL_WAIT, GhostMode=00, frightened=0, mode_change=0;
  - sched_cnt=0, fright_cnt=0, phase=0.
- Event priority within one cycle: rst_n > game_reset > eaten > fright > tick.
- States:
  - JAIL_WAIT (00): sched_cnt increments on each tick. When sched_cnt reaches RELEASE_TICKS-1 on a tick, go to EXIT. RELEASE_TICKS=0 exits on the first tick.
  - EXIT (00): when GhostPos == (10,9), go to SCATTER if phase is even, else CHASE. sched_cnt is cleared on entry.
  - SCATTER (01) and CHASE (10): sched_cnt advances on tick, and only while frightened=0.
    - At the phase limit: phase increments, sched_cnt clears, state toggles, and mode_change pulses.
    - Phase 7 is CHASE with no limit; phase saturates at 7.
    - The phase limit is sampled from level at the moment of the compare.
  - EATEN (11): entered from SCATTER/CHASE when eaten=1 and frightened=1. On entry frightened=0 and fright_cnt=0.
    - When GhostPos == (10,12), go to JAIL_WAIT with sched_cnt loaded so that release follows 8 ticks later.
    - phase is retained.
- Frightened handling:
  - A fright pulse in SCATTER/CHASE sets frightened=1, loads fright_cnt with FRIGHT_L0 or FRIGHT_L1 by level, and pulses mode_change.
  - A fright pulse while already frightened reloads fright_cnt with no extra mode_change.
  - fright_cnt decrements on tick. On reaching 0, frightened=0 and the schedule resumes from the held sched_cnt.
  - A fright pulse in JAIL_WAIT, EXIT or EATEN is ignored.
  - eaten while frightened=0 is ignored (Pac-Man death is handled by game_reset).
- Simultaneous eaten and fright in the same cycle: eaten wins, state goes to EATEN, and fright is dropped.
- Outputs:
  - GhostMode is registered and updates in the cycle after the state change.
  - mode_change is registered and high for exactly one clk_50mhz cycle.
- Counters: 10-bit unsigned with no wrap. sched_cnt holds at its limit if tick arrives while the state change is pending.

Optional Feature:
Macro GHOST_ELROY_EN.
- Defined: while dots_low=1 and state is SCATTER, GhostMode outputs 10. The scatter timer still runs and the phase sequence is unchanged.
- Undefined: dots_low is ignored.

Test Plan:
- Reset with RELEASE_TICKS=32, then 31 ticks -> GhostMode=00, state JAIL_WAIT. The 32nd tick -> EXIT. Drive GhostPos=(10,9) -> GhostMode=01 in the next cycle.
- In SCATTER at level 0, 112 ticks -> GhostMode=10 with one mode_change pulse. A further 320 ticks -> 01 and a second pulse. After phase 7, 2000 ticks -> GhostMode stays 10.
- In CHASE, fright pulse -> frightened=1 and mode_change pulse. Fright again at tick 50 -> no pulse and reload. At level 0, frightened clears 96 ticks after the second pulse, and sched_cnt resumes from its held value.
- Frightened, then eaten and fright pulsed in the same cycle -> GhostMode=11, frightened=0. GhostPos=(10,12) -> GhostMode=00. 8 ticks later -> EXIT.
- rst_n low mid-fright in CHASE -> all outputs 0 immediately, without waiting for a clock. Separately, game_reset in EATEN -> JAIL_WAIT, phase=0.
- With GHOST_ELROY_EN defined, dots_low=1 in SCATTER -> GhostMode=10. With the macro undefined, the same stimulus -> GhostMode=01.
